// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and helpers for the M-extension execute unit.
package muldiv_pkg;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

  function automatic logic is_signed_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider (one quotient bit per cycle); with MULDIV_ITERATIVE_MUL_EN the same
// registers also run a shift-add multiply. last marks the final iteration; results hold until the next start.
module div_core #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
`ifdef MULDIV_ITERATIVE_MUL_EN
  input  logic            mul,
  output logic [XLEN-1:0] step_hi,
  output logic [XLEN-1:0] step_lo,
`endif
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q, quo_q, dsr_q, rem_n, quo_n;
  logic [XLEN:0]    partial, diff;

  // Dividend bits shift out of the top of quo_q while quotient bits shift in at the bottom.
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign diff    = partial - {1'b0, dsr_q};

`ifdef MULDIV_ITERATIVE_MUL_EN
  logic          mul_q;
  logic [XLEN:0] sum;

  // Multiply mode: {rem_q, quo_q} is the product accumulator, multiplier bits consumed from quo_q[0].
  assign sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dsr_q} : '0);

  always_comb begin
    if (mul_q) begin
      rem_n = sum[XLEN:1];
      quo_n = {sum[0], quo_q[XLEN-1:1]};
    end else begin
      rem_n = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  assign step_hi = rem_n;
  assign step_lo = quo_n;
`else
  assign rem_n = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n = {quo_q[XLEN-2:0], ~diff[XLEN]};
`endif

  assign last      = active & (cnt == CNT_W'(ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
`ifdef MULDIV_ITERATIVE_MUL_EN
      mul_q  <= 1'b0;
`endif
    end else if (kill) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dsr_q  <= divisor;
`ifdef MULDIV_ITERATIVE_MUL_EN
      mul_q  <= mul;
`endif
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (last) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// M-extension execute unit: multiply in 2 cycles (33 with MULDIV_ITERATIVE_MUL_EN), divide 34, divide special case 1.
// busy_o stalls the pipeline from the start cycle onward; kill_i aborts any operation with no done_o.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            kill_i,
  input  logic [3:0]      mulDiv_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state, next_state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic            start, special, core_start, core_last, load_res;
  logic            in_sa, in_sb, mul_sa, mul_sb, fix_sa, fix_sb;
  logic [XLEN-1:0] abs_a, abs_b, special_res, res_d, mul_res, div_res;
  logic [XLEN-1:0] quotient, remainder, core_dividend, core_divisor;

  assign start = valid_i & (mulDiv_op_i != OP_NONE) & (state == IDLE) & ~kill_i;

  assign in_sa = is_signed_div(mulDiv_op_i) & op_a_i[XLEN-1];
  assign in_sb = is_signed_div(mulDiv_op_i) & op_b_i[XLEN-1];
  assign abs_a = in_sa ? -op_a_i : op_a_i;
  assign abs_b = in_sb ? -op_b_i : op_b_i;

  // Divide by zero and signed overflow bypass the iterative divider entirely.
  assign special = (op_b_i == '0) |
                   (is_signed_div(mulDiv_op_i) & (op_a_i == MIN_NEG) & (op_b_i == ALL_ONES));
  assign special_res = (op_b_i == '0) ? (mulDiv_op_i[2] ? op_a_i : ALL_ONES)
                                      : (mulDiv_op_i[2] ? '0 : MIN_NEG);

  assign mul_sa = (op_q == OP_MULH) | (op_q == OP_MULHSU);
  assign mul_sb = (op_q == OP_MULH);

`ifdef MULDIV_ITERATIVE_MUL_EN
  logic [XLEN-1:0] step_hi, step_lo, hi_fix;

  // The shift-add runs unsigned; a signed operand's weight of -2^XLEN is removed from the high half.
  assign hi_fix = step_hi - ((mul_sa & a_q[XLEN-1]) ? b_q : '0)
                          - ((mul_sb & b_q[XLEN-1]) ? a_q : '0);
  assign mul_res       = (op_q == OP_MUL) ? step_lo : hi_fix;
  assign core_dividend = mulDiv_op_i[3] ? abs_a : op_b_i;
  assign core_divisor  = mulDiv_op_i[3] ? abs_b : op_a_i;
`else
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  assign a_ext         = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
  assign b_ext         = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
  assign prod          = a_ext * b_ext;
  assign mul_res       = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign core_dividend = abs_a;
  assign core_divisor  = abs_b;
`endif

  assign fix_sa  = is_signed_div(op_q) & a_q[XLEN-1];
  assign fix_sb  = is_signed_div(op_q) & b_q[XLEN-1];
  assign div_res = op_q[2] ? (fix_sa ? -remainder : remainder)
                           : ((fix_sa ^ fix_sb) ? -quotient : quotient);

  div_core #(
    .XLEN  (XLEN),
    .ITERS (DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .kill      (kill_i),
`ifdef MULDIV_ITERATIVE_MUL_EN
    .mul       (~mulDiv_op_i[3]),
    .step_hi   (step_hi),
    .step_lo   (step_lo),
`endif
    .dividend  (core_dividend),
    .divisor   (core_divisor),
    .last      (core_last),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    next_state = state;
    core_start = 1'b0;
    load_res   = 1'b0;
    res_d      = special_res;
    case (state)
      IDLE: begin
        if (start) begin
          if (!mulDiv_op_i[3]) begin
            next_state = MUL;
`ifdef MULDIV_ITERATIVE_MUL_EN
            core_start = 1'b1;
`endif
          end else if (special) begin
            next_state = DONE;
            load_res   = 1'b1;
            res_d      = special_res;
          end else begin
            next_state = DIV;
            core_start = 1'b1;
          end
        end
      end
      MUL: begin
`ifdef MULDIV_ITERATIVE_MUL_EN
        if (core_last) begin
          next_state = DONE;
          load_res   = 1'b1;
          res_d      = mul_res;
        end
`else
        next_state = DONE;
        load_res   = 1'b1;
        res_d      = mul_res;
`endif
      end
      DIV: if (core_last) next_state = FIX;
      FIX: begin
        next_state = DONE;
        load_res   = 1'b1;
        res_d      = div_res;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill_i) begin
      next_state = IDLE;
      core_start = 1'b0;
      load_res   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        op_q <= mulDiv_op_i;
        a_q  <= op_a_i;
        b_q  <= op_b_i;
      end
      if (load_res) result_q <= res_d;
    end
  end

  assign busy_o   = (state != IDLE) | start;
  assign done_o   = (state == DONE) & ~kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic RISC-V M-extension model.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [3:0] C_MUL    = 4'b0011;
  localparam logic [3:0] C_MULH   = 4'b0101;
  localparam logic [3:0] C_MULHSU = 4'b0110;
  localparam logic [3:0] C_MULHU  = 4'b0111;
  localparam logic [3:0] C_DIV    = 4'b1001;
  localparam logic [3:0] C_DIVU   = 4'b1011;
  localparam logic [3:0] C_REM    = 4'b1101;
  localparam logic [3:0] C_REMU   = 4'b1111;
`ifdef MULDIV_ITERATIVE_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .kill_i      (kill_i),
    .mulDiv_op_i (op),
    .op_a_i      (a),
    .op_b_i      (b),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy;
    longint      lx, ly, ux, uy;
    logic [63:0] p;
    sx = x; sy = y;
    lx = sx; ly = sy;
    ux = {32'd0, x}; uy = {32'd0, y};
    case (o)
      C_MUL:    begin p = lx * ly; return p[31:0];  end
      C_MULH:   begin p = lx * ly; return p[63:32]; end
      C_MULHSU: begin p = lx * uy; return p[63:32]; end
      C_MULHU:  begin p = ux * uy; return p[63:32]; end
      C_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      C_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      C_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      C_REMU:  return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[3]) return MUL_LAT;
    if (y == 0) return 1;
    if ((o == C_DIV || o == C_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a falling edge; returns at the falling edge of the IDLE cycle after done_o.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] want;
    int          lat, want_lat;
    want     = model(o, x, y);
    want_lat = exp_lat(o, x, y);
    valid_i = 1'b1; op = o; a = x; b = y;
    #1 check_val({tag, "_busy_start"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    valid_i = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (done_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(want_lat));
    check_val({tag, "_res"}, result_o, want);
    check_val({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check_val({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
  endtask

  logic [3:0]  ops [8] = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
  logic [31:0] prev;
  logic        saw_done;

  initial begin
    #1 rst = 1'b1;
    #2;
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mulh",   C_MULH,   32'hFFFF_FFFF, 32'd2);
    run_op("mulhu",  C_MULHU,  32'hFFFF_FFFF, 32'd2);
    run_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'd2);
    run_op("div_n7", C_DIV,    32'hFFFF_FFF9, 32'd2);
    run_op("rem_n7", C_REM,    32'hFFFF_FFF9, 32'd2);
    run_op("divu7",  C_DIVU,   32'd7, 32'd2);
    run_op("divu_z", C_DIVU,   32'd5, 32'd0);
    run_op("remu_z", C_REMU,   32'd5, 32'd0);
    run_op("div_ov", C_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ov", C_REM,    32'h8000_0000, 32'hFFFF_FFFF);

    // kill mid-divide
    prev = result_o;
    valid_i = 1'b1; op = C_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check_val("kill_busy", {31'd0, busy_o}, 32'd0);
    check_val("kill_done", {31'd0, done_o}, 32'd0);
    check_val("kill_result", result_o, prev);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    check_val("kill_nodone", {31'd0, saw_done}, 32'd0);
    run_op("mul_6x7", C_MUL, 32'd6, 32'd7);

    // kill in the start cycle suppresses the start
    valid_i = 1'b1; op = C_MUL; a = 32'd9; b = 32'd9; kill_i = 1'b1;
    #1 check_val("kstart_busy0", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    check_val("kstart_busy1", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check_val("kstart_done", {31'd0, done_o}, 32'd0);

    // op 0000 with valid does nothing
    valid_i = 1'b1; op = C_NONE; a = $urandom; b = $urandom;
    #1 check_val("none_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    check_val("none_done", {31'd0, done_o}, 32'd0);
    check_val("none_result", result_o, 32'd42);

    // asynchronous reset mid-divide
    valid_i = 1'b1; op = C_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", {31'd0, busy_o}, 32'd0);
    check_val("arst_done", {31'd0, done_o}, 32'd0);
    check_val("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("remu_17_5", C_REMU, 32'd17, 32'd5);

    run_op("b2b_3x4", C_MUL, 32'd3, 32'd4);
    run_op("b2b_5x5", C_MUL, 32'd5, 32'd5);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      int          sel;
      ro  = ops[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'($urandom_range(1, 15));
      if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 3) ra = 32'($urandom_range(0, 255));
      run_op("rnd", ro, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
